// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial receive path.
// Optional parity support is enabled by defining SERIAL_RX_PARITY_EN.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } rx_state_t;

  localparam int SERIAL_WIDTH_DEF = 8;

  // Even parity over up to 32 bits; narrower words are zero-extended by the caller.
  function automatic logic even_parity(input logic [31:0] vec);
    return ^vec;
  endfunction

endpackage

// File: rtl/rx_out_buf.sv
// Single-entry valid/ready holding register for received words.
// A word that completes while the entry is full and not being drained is dropped and flagged.
module rx_out_buf
  import serial_pkg::*;
#(
  parameter int WIDTH = SERIAL_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data,
  output logic             out_valid,
  output logic             overrun
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             can_accept;

  // A slot frees up at the same edge the consumer takes the current word.
  always_comb begin
    data_d     = data_q;
    valid_d    = valid_q;
    overrun_d  = 1'b0;
    can_accept = !valid_q || out_ready;
    if (push && can_accept) begin
      data_d  = push_data;
      valid_d = 1'b1;
    end else if (push) begin
      overrun_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data      = data_q;
  assign out_valid = valid_q;
  assign overrun   = overrun_q;

endmodule

// File: rtl/serial_rx_8b.sv
// Serial-to-parallel receiver: bits sampled on bit_en while frame is high, words handed to rx_out_buf.
// Define SERIAL_RX_PARITY_EN to expect a trailing even-parity bit and expose parity_err.
module serial_rx_8b
  import serial_pkg::*;
#(
  parameter int WIDTH     = SERIAL_WIDTH_DEF,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             frame,
  input  logic             s_in,
  output logic [WIDTH-1:0] data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  output logic             overrun
`ifdef SERIAL_RX_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
`ifdef SERIAL_RX_PARITY_EN
  localparam int BW = WIDTH + 1;
`else
  localparam int BW = WIDTH;
`endif

  rx_state_t        state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             frame_err_q, frame_err_d;
  logic [WIDTH-1:0] shifted;
  logic             push;
  logic [WIDTH-1:0] push_word;
  logic [BW-1:0]    push_data;
  logic [BW-1:0]    buf_data;
`ifdef SERIAL_RX_PARITY_EN
  logic             push_perr;
`endif

  always_comb begin
    if (MSB_FIRST != 0) begin
      shifted = {sr_q[WIDTH-2:0], s_in};
    end else begin
      shifted = {s_in, sr_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    push_word   = shifted;
`ifdef SERIAL_RX_PARITY_EN
    push_perr   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (bit_en && frame) begin
          sr_d    = shifted;
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!frame) begin
          frame_err_d = 1'b1;
          cnt_d       = '0;
          state_d     = IDLE;
        end else if (bit_en) begin
          sr_d = shifted;
          if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
`ifdef SERIAL_RX_PARITY_EN
            state_d = PARITY;
`else
            push    = 1'b1;
            state_d = IDLE;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      // The assembled word waits in sr_q until its parity bit arrives.
      PARITY: begin
        if (!frame) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else if (bit_en) begin
          push      = 1'b1;
          push_word = sr_q;
          push_perr = even_parity(32'(sr_q)) ^ s_in;
          state_d   = IDLE;
        end
      end
`endif
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  assign push_data  = {push_perr, push_word};
  assign data       = buf_data[WIDTH-1:0];
  assign parity_err = buf_data[WIDTH];
`else
  assign push_data  = push_word;
  assign data       = buf_data;
`endif
  assign frame_err = frame_err_q;

  rx_out_buf #(
    .WIDTH(BW)
  ) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .out_ready (out_ready),
    .data      (buf_data),
    .out_valid (out_valid),
    .overrun   (overrun)
  );

endmodule

// File: tb/tb_serial_rx_8b.sv
// Self-checking bench for serial_rx_8b: MSB-first and LSB-first instances share one input stream.
// Honours SERIAL_RX_PARITY_EN when the design is built with it.
module tb_serial_rx_8b;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bit_en = 1'b0;
  logic frame = 1'b0;
  logic s_in = 1'b0;
  logic out_ready = 1'b0;

  logic [W-1:0] data_m, data_l;
  logic valid_m, valid_l, ferr_m, ferr_l, ovr_m, ovr_l;
`ifdef SERIAL_RX_PARITY_EN
  logic perr_m, perr_l;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_rx_8b #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst(rst), .bit_en(bit_en), .frame(frame), .s_in(s_in),
    .data(data_m), .out_valid(valid_m), .out_ready(out_ready),
    .frame_err(ferr_m), .overrun(ovr_m)
`ifdef SERIAL_RX_PARITY_EN
    , .parity_err(perr_m)
`endif
  );

  serial_rx_8b #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .bit_en(bit_en), .frame(frame), .s_in(s_in),
    .data(data_l), .out_valid(valid_l), .out_ready(out_ready),
    .frame_err(ferr_l), .overrun(ovr_l)
`ifdef SERIAL_RX_PARITY_EN
    , .parity_err(perr_l)
`endif
  );

  // Reference model: bits collected in arrival order, word formed once W have arrived.
  bit           m_bits[$];
  logic         m_await_par = 1'b0;
  logic [W-1:0] m_pend_m, m_pend_l;
  logic         m_valid = 1'b0, m_perr = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;
  logic [W-1:0] m_data_m = '0, m_data_l = '0;

  task automatic model_edge(input logic be, input logic fr, input logic s, input logic rdy, input logic rs);
    logic done;
    logic pe;
    done = 1'b0;
    pe   = 1'b0;
    if (rs) begin
      m_bits.delete();
      m_await_par = 1'b0;
      m_valid = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
      m_data_m = '0; m_data_l = '0;
      return;
    end
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    if (m_await_par) begin
      if (!fr) begin
        m_ferr = 1'b1;
        m_await_par = 1'b0;
      end else if (be) begin
        pe = (^m_pend_m) ^ s;
        done = 1'b1;
        m_await_par = 1'b0;
      end
    end else if (m_bits.size() > 0) begin
      if (!fr) begin
        m_ferr = 1'b1;
        m_bits.delete();
      end else if (be) begin
        m_bits.push_back(s);
        if (m_bits.size() == W) begin
          for (int i = 0; i < W; i++) begin
            m_pend_m[W-1-i] = m_bits[i];
            m_pend_l[i]     = m_bits[i];
          end
          m_bits.delete();
`ifdef SERIAL_RX_PARITY_EN
          m_await_par = 1'b1;
`else
          done = 1'b1;
`endif
        end
      end
    end else if (be && fr) begin
      m_bits.push_back(s);
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_data_m = m_pend_m;
        m_data_l = m_pend_l;
        m_perr   = pe;
        m_valid  = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic step(input logic be, input logic fr, input logic s, input logic rdy, input logic rs);
    @(negedge clk);
    bit_en = be; frame = fr; s_in = s; out_ready = rdy; rst = rs;
    @(posedge clk);
    model_edge(be, fr, s, rdy, rs);
    #1;
  endtask

  task automatic gap(input logic rdy);
    repeat ($urandom_range(0, 3)) step(1'b0, 1'b1, 1'($urandom), rdy, 1'b0);
  endtask

  task automatic send_bits(input logic [W-1:0] w, input int n, input logic rdy);
    for (int i = 0; i < n; i++) begin
      gap(rdy);
      step(1'b1, 1'b1, w[W-1-i], rdy, 1'b0);
    end
  endtask

  task automatic finish_word(input logic b, input logic rdy_gap, input logic rdy_last, input logic par);
    gap(rdy_gap);
`ifdef SERIAL_RX_PARITY_EN
    step(1'b1, 1'b1, b, rdy_gap, 1'b0);
    gap(rdy_gap);
    step(1'b1, 1'b1, par, rdy_last, 1'b0);
`else
    if (par) begin end
    step(1'b1, 1'b1, b, rdy_last, 1'b0);
`endif
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic rdy_body, input logic rdy_last);
    send_bits(w, W - 1, rdy_body);
    finish_word(w[0], rdy_body, rdy_last, ^w);
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++; if (data_m !== 8'h00) begin errors++; $display("[TB] FAIL reset_data_m: got %h expected %h", data_m, 8'h00); end
    checks++; if (data_l !== 8'h00) begin errors++; $display("[TB] FAIL reset_data_l: got %h expected %h", data_l, 8'h00); end
    checks++; if (valid_m !== 1'b0 || valid_l !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b%b expected 00", valid_m, valid_l); end
    checks++; if (ferr_m !== 1'b0 || ovr_m !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulses: got ferr=%b ovr=%b expected 0 0", ferr_m, ovr_m); end
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_msb_first();
    send_bits(8'hA5, W - 1, 1'b0);
    checks++; if (valid_m !== 1'b0) begin errors++; $display("[TB] FAIL a5_early_valid: got %b expected %b", valid_m, 1'b0); end
    finish_word(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (valid_m !== 1'b1) begin errors++; $display("[TB] FAIL a5_valid: got %b expected %b", valid_m, 1'b1); end
    checks++; if (data_m !== 8'hA5) begin errors++; $display("[TB] FAIL a5_data_m: got %h expected %h", data_m, 8'hA5); end
    checks++; if (data_l !== 8'hA5) begin errors++; $display("[TB] FAIL a5_data_l: got %h expected %h", data_l, 8'hA5); end
    checks++; if (ferr_m !== 1'b0) begin errors++; $display("[TB] FAIL a5_ferr: got %b expected %b", ferr_m, 1'b0); end
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++; if (valid_m !== 1'b0) begin errors++; $display("[TB] FAIL a5_consume: got %b expected %b", valid_m, 1'b0); end
  endtask

  task automatic test_lsb_first();
    send_word(8'hF0, 1'b0, 1'b0);
    checks++; if (data_l !== 8'h0F) begin errors++; $display("[TB] FAIL lsb_data: got %h expected %h", data_l, 8'h0F); end
    checks++; if (data_m !== 8'hF0) begin errors++; $display("[TB] FAIL msb_data: got %h expected %h", data_m, 8'hF0); end
    checks++; if (valid_l !== 1'b1) begin errors++; $display("[TB] FAIL lsb_valid: got %b expected %b", valid_l, 1'b1); end
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_overrun();
    send_word(8'h3C, 1'b0, 1'b0);
    send_word(8'hC3, 1'b0, 1'b0);
    checks++; if (ovr_m !== 1'b1 || ovr_l !== 1'b1) begin errors++; $display("[TB] FAIL ovr_pulse: got %b%b expected 11", ovr_m, ovr_l); end
    checks++; if (data_m !== 8'h3C) begin errors++; $display("[TB] FAIL ovr_keep: got %h expected %h", data_m, 8'h3C); end
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (ovr_m !== 1'b0) begin errors++; $display("[TB] FAIL ovr_one_cycle: got %b expected %b", ovr_m, 1'b0); end
    checks++; if (valid_m !== 1'b1) begin errors++; $display("[TB] FAIL ovr_still_valid: got %b expected %b", valid_m, 1'b1); end
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++; if (valid_m !== 1'b0) begin errors++; $display("[TB] FAIL ovr_drain: got %b expected %b", valid_m, 1'b0); end
  endtask

  task automatic test_back_to_back();
    send_word(8'h3C, 1'b0, 1'b0);
    send_word(8'h55, 1'b0, 1'b1);
    checks++; if (data_m !== 8'h55) begin errors++; $display("[TB] FAIL b2b_data_m: got %h expected %h", data_m, 8'h55); end
    checks++; if (data_l !== 8'hAA) begin errors++; $display("[TB] FAIL b2b_data_l: got %h expected %h", data_l, 8'hAA); end
    checks++; if (valid_m !== 1'b1 || ovr_m !== 1'b0) begin errors++; $display("[TB] FAIL b2b_flags: got valid=%b ovr=%b expected 1 0", valid_m, ovr_m); end
  endtask

  task automatic test_frame_abort();
    send_bits(8'h96, 5, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (ferr_m !== 1'b1 || ferr_l !== 1'b1) begin errors++; $display("[TB] FAIL abort_ferr: got %b%b expected 11", ferr_m, ferr_l); end
    checks++; if (valid_m !== 1'b1 || data_m !== 8'h55) begin errors++; $display("[TB] FAIL abort_buf: got %b/%h expected 1/55", valid_m, data_m); end
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (ferr_m !== 1'b0) begin errors++; $display("[TB] FAIL abort_one_cycle: got %b expected %b", ferr_m, 1'b0); end
    send_word(8'hFF, 1'b1, 1'b1);
    checks++; if (data_m !== 8'hFF || valid_m !== 1'b1) begin errors++; $display("[TB] FAIL abort_next: got %b/%h expected 1/ff", valid_m, data_m); end
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_word();
    send_bits(8'hC3, 4, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++; if (data_m !== 8'h00 || valid_m !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_buf: got %b/%h expected 0/00", valid_m, data_m); end
    checks++; if (ferr_m !== 1'b0 || ovr_m !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_pulses: got %b%b expected 00", ferr_m, ovr_m); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (ferr_m !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_noferr: got %b expected %b", ferr_m, 1'b0); end
    send_bits(8'h81, W - 1, 1'b0);
    finish_word(1'b1, 1'b0, 1'b0, 1'b1);
    checks++; if (data_m !== 8'h81 || valid_m !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_81: got %b/%h expected 1/81", valid_m, data_m); end
`ifdef SERIAL_RX_PARITY_EN
    checks++; if (perr_m !== 1'b1) begin errors++; $display("[TB] FAIL parity_bad: got %b expected %b", perr_m, 1'b1); end
    send_bits(8'h81, W - 1, 1'b0);
    finish_word(1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (perr_m !== 1'b0) begin errors++; $display("[TB] FAIL parity_good: got %b expected %b", perr_m, 1'b0); end
`endif
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic be, fr, s, rdy, rs;
    for (int c = 0; c < 1500; c++) begin
      fr  = ($urandom_range(0, 39) != 0);
      be  = 1'($urandom_range(0, 1));
      s   = 1'($urandom);
      rdy = ($urandom_range(0, 2) == 0);
      rs  = ($urandom_range(0, 299) == 0);
      step(be, fr, s, rdy, rs);
      checks++; if (valid_m !== m_valid || valid_l !== m_valid) begin errors++; $display("[TB] FAIL rnd_valid c=%0d: got %b%b expected %b", c, valid_m, valid_l, m_valid); end
      checks++; if (data_m !== m_data_m) begin errors++; $display("[TB] FAIL rnd_data_m c=%0d: got %h expected %h", c, data_m, m_data_m); end
      checks++; if (data_l !== m_data_l) begin errors++; $display("[TB] FAIL rnd_data_l c=%0d: got %h expected %h", c, data_l, m_data_l); end
      checks++; if (ferr_m !== m_ferr || ferr_l !== m_ferr) begin errors++; $display("[TB] FAIL rnd_ferr c=%0d: got %b%b expected %b", c, ferr_m, ferr_l, m_ferr); end
      checks++; if (ovr_m !== m_ovr || ovr_l !== m_ovr) begin errors++; $display("[TB] FAIL rnd_ovr c=%0d: got %b%b expected %b", c, ovr_m, ovr_l, m_ovr); end
`ifdef SERIAL_RX_PARITY_EN
      checks++; if (m_valid && (perr_m !== m_perr || perr_l !== m_perr)) begin errors++; $display("[TB] FAIL rnd_perr c=%0d: got %b%b expected %b", c, perr_m, perr_l, m_perr); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_overrun();
    test_back_to_back();
    test_frame_abort();
    test_reset_mid_word();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
